execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Third stage of the 5-stage pipelined MIPS core. Sits directly downstream of the decode stage and upstream of the memory stage.
- Consumes the decoded E-stage operands and controls, and selects forwarded operands from M/W.
- Performs the ALU operation and computes the branch target and destination register.
- Registers all results into the E/M pipeline register.

Parameters:
- DATA_W, 32, datapath width (operands, PC, results)
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous reset, active-high
- RD1E  in  DATA_W  register-file operand A from decode
- RD2E  in  DATA_W  register-file operand B from decode
- SignImmE  in  DATA_W  sign-extended immediate
- PCPlus4E  in  DATA_W  PC+4 of the E-stage instruction
- RtE  in  REG_AW  rt field
- RdE  in  REG_AW  rd field
- RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE  in  1 each  decoded controls
- ALUControlE  in  3  ALU operation select
- ForwardAE  in  2  operand A source select (from hazard unit)
- ForwardBE  in  2  operand B source select
- ResultW  in  DATA_W  writeback-stage result for forwarding
- FlushM  in  1  bubble insert into M stage
- WriteRegE  out  REG_AW  combinational destination register (to hazard unit)
- ALUOutM  out  DATA_W  registered ALU result
- WriteDataM  out  DATA_W  registered store data (forwarded B, pre-ALUSrc mux)
- WriteRegM  out  REG_AW  registered destination register
- PCBranchM  out  DATA_W  registered branch target
- ZeroM  out  1  registered ALU zero flag
- RegWriteM, MemtoRegM, MemWriteM, BranchM  out  1 each  registered controls

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a rising edge, all M outputs clear to 0 (ALUOutM, WriteDataM, WriteRegM, PCBranchM, ZeroM, and all control outputs).
- Forward muxes (combinational), applied identically to A (ForwardAE, RD1E) and B (ForwardBE, RD2E):
  - 00 selects RD*E
  - 01 selects ResultW
  - 10 selects ALUOutM (the block's own registered output)
  - 11 is reserved and selects RD*E
- SrcBE = ALUSrcE ? SignImmE : forwarded B.
- ALU, by ALUControlE:
  - 010 add
  - 110 sub
  - 000 and
  - 001 or
  - 111 slt (signed compare: 1 if A<B, else 0)
  - any other code gives result 0
- Arithmetic wraps modulo 2^DATA_W.
- Zero = (ALU result == 0).
- WriteRegE = RegDstE ? RdE : RtE. It is combinational and valid in the same cycle.
- PCBranch = (SignImmE << 2) + PCPlus4E, truncated to DATA_W.
- Latency: exactly 1 cycle. Every M output reflects the E inputs sampled at the previous rising edge. No stall input; the stage always advances.
- FlushM=1 (rst=0): RegWriteM, MemtoRegM, MemWriteM and BranchM load 0. Data fields load normally (don't-care).
- rst and FlushM asserted together: rst dominates, so everything is 0.
- Reset mid-operation: the in-flight instruction is discarded and no write is issued from M on the next cycle.
- Forwarding from ALUOutM uses the pre-edge value, so a back-to-back dependent pair produces the correct result.

Optional Feature:
- Macro: EXE_OVERFLOW_TRAP_EN.
- When defined:
  - Signed overflow is detected on add and sub: the operand signs agree (with B inverted for sub) and the result sign differs.
  - On overflow, RegWriteM and MemWriteM are forced to 0.
  - Extra output OverflowM (1 bit, reset 0, cleared by FlushM) is registered high for that instruction.
- When undefined: no OverflowM port, and results wrap silently.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode localparams: ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_AND=3'b000, ALU_OR=3'b001, ALU_SLT=3'b111.
  - Forward select localparams: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module: alu, which is combinational (SrcA, SrcB, ALUControl -> ALUResult, Zero, plus Overflow under the macro).
- The E/M register stays in execute_cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with nonzero inputs -> all M outputs are 0. Release and apply RD1E=5, RD2E=3, ALUControlE=010, ALUSrcE=0 -> next cycle ALUOutM=8, ZeroM=0.
- Forwarding: cycle 1 produces ALUOutM=0x10. Cycle 2 sets ForwardAE=10, RD1E=0xDEAD, RD2E=1, add -> ALUOutM=0x11. Then ForwardBE=01, ResultW=7, RD1E=2, sub -> ALUOutM=0xFFFFFFFB.
- Immediate/branch: ALUSrcE=1, SignImmE=0xFFFFFFFC, PCPlus4E=0x100, RD1E=4, add -> ALUOutM=0, ZeroM=1, PCBranchM=0xF0. Sub with A=B=9 and BranchE=1 -> ZeroM=1, BranchM=1.
- SLT / WriteReg: A=0xFFFFFFFF, B=1, op 111 -> ALUOutM=1. Swapping the operands -> 0. RegDstE=1 with RdE=12, RtE=3 -> WriteRegE=12 the same cycle and WriteRegM=12 the next cycle. RegDstE=0 -> 3.
- Flush: RegWriteE=MemWriteE=BranchE=1 with FlushM=1 -> all four M controls are 0. rst=1 together with FlushM=1 -> all outputs are 0.
- EXE_OVERFLOW_TRAP_EN: add 0x7FFFFFFF+1 with RegWriteE=1 -> OverflowM=1, RegWriteM=0. Add 1+1 -> OverflowM=0. With the macro undefined, the same add gives ALUOutM=0x80000000 and RegWriteM=1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU opcode and forward-select constants for the MIPS pipeline
package mips_pkg;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; Overflow output exists only with EXE_OVERFLOW_TRAP_EN
import mips_pkg::*;

module alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic [2:0]        ALUControl,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero
`ifdef EXE_OVERFLOW_TRAP_EN
    ,
    output logic              Overflow
`endif
);

    logic w_lt;

    assign w_lt = ($signed(SrcA) < $signed(SrcB));

    // operation select; undefined codes produce zero
    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_SLT: ALUResult = {{(DATA_W-1){1'b0}}, w_lt};
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

`ifdef EXE_OVERFLOW_TRAP_EN
    // signed overflow: operands agree in sign (B inverted for sub) but the result does not
    always_comb begin
        Overflow = 1'b0;
        if (ALUControl == ALU_ADD)
            Overflow = (SrcA[DATA_W-1] == SrcB[DATA_W-1]) &&
                       (ALUResult[DATA_W-1] != SrcA[DATA_W-1]);
        else if (ALUControl == ALU_SUB)
            Overflow = (SrcA[DATA_W-1] != SrcB[DATA_W-1]) &&
                       (ALUResult[DATA_W-1] != SrcA[DATA_W-1]);
    end
`endif

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - MIPS execute stage with forwarding muxes and E/M register; optional EXE_OVERFLOW_TRAP_EN
import mips_pkg::*;

module execute_cycle #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] SignImmE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              ALUSrcE,
    input  logic              RegDstE,
    input  logic [2:0]        ALUControlE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              FlushM,
    output logic [REG_AW-1:0] WriteRegE,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_AW-1:0] WriteRegM,
    output logic [DATA_W-1:0] PCBranchM,
    output logic              ZeroM,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic              BranchM
`ifdef EXE_OVERFLOW_TRAP_EN
    ,
    output logic              OverflowM
`endif
);

    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] w_src_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_src_b;
    logic [DATA_W-1:0] w_alu_result;
    logic [DATA_W-1:0] w_pc_branch;
    logic              w_zero;
    logic              w_trap;

    // operand A source; reserved code falls back to the register file
    always_comb begin
        w_src_a = RD1E;
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_alu_out;
            default: w_src_a = RD1E;
        endcase
    end

    // operand B source; this value is also the store data
    always_comb begin
        w_fwd_b = RD2E;
        case (ForwardBE)
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = r_alu_out;
            default: w_fwd_b = RD2E;
        endcase
    end

    assign w_src_b     = ALUSrcE ? SignImmE : w_fwd_b;
    assign WriteRegE   = RegDstE ? RdE : RtE;
    assign w_pc_branch = (SignImmE << 2) + PCPlus4E;

    alu #(.DATA_W(DATA_W)) u_alu (
        .SrcA       (w_src_a),
        .SrcB       (w_src_b),
        .ALUControl (ALUControlE),
        .ALUResult  (w_alu_result),
        .Zero       (w_zero)
`ifdef EXE_OVERFLOW_TRAP_EN
        ,
        .Overflow   (w_trap)
`endif
    );

`ifndef EXE_OVERFLOW_TRAP_EN
    assign w_trap = 1'b0;
`endif

    // E/M pipeline register; reset beats flush, flush only bubbles the controls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out  <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
            PCBranchM  <= '0;
            ZeroM      <= 1'b0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            BranchM    <= 1'b0;
`ifdef EXE_OVERFLOW_TRAP_EN
            OverflowM  <= 1'b0;
`endif
        end else begin
            r_alu_out  <= w_alu_result;
            WriteDataM <= w_fwd_b;
            WriteRegM  <= WriteRegE;
            PCBranchM  <= w_pc_branch;
            ZeroM      <= w_zero;
            RegWriteM  <= RegWriteE & ~FlushM & ~w_trap;
            MemtoRegM  <= MemtoRegE & ~FlushM;
            MemWriteM  <= MemWriteE & ~FlushM & ~w_trap;
            BranchM    <= BranchE   & ~FlushM;
`ifdef EXE_OVERFLOW_TRAP_EN
            OverflowM  <= w_trap & ~FlushM;
`endif
        end
    end

    assign ALUOutM = r_alu_out;

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - scoreboard bench for execute_cycle, default build or EXE_OVERFLOW_TRAP_EN
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E, ResultW;
    logic [4:0]  RtE, RdE;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        FlushM;
    logic [4:0]  WriteRegE, WriteRegM;
    logic [31:0] ALUOutM, WriteDataM, PCBranchM;
    logic        ZeroM, RegWriteM, MemtoRegM, MemWriteM, BranchM;
    logic        ov_obs;
`ifdef EXE_OVERFLOW_TRAP_EN
    logic        OverflowM;
    assign ov_obs = OverflowM;
`else
    assign ov_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .PCPlus4E(PCPlus4E), .RtE(RtE), .RdE(RdE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .FlushM(FlushM), .WriteRegE(WriteRegE), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .PCBranchM(PCBranchM),
        .ZeroM(ZeroM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .BranchM(BranchM)
`ifdef EXE_OVERFLOW_TRAP_EN
        , .OverflowM(OverflowM)
`endif
    );

    typedef struct {
        logic [31:0] alu, wd, pcb;
        logic [4:0]  wr;
        logic        z, rw, mr, mw, br, ov;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_alu    = 32'h0;  // model copy of ALUOutM for forwarding

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // one instruction: predict, push, clock, pop and compare
    task automatic go();
        exp_t        e;
        logic [31:0] a, bf, b, r;
        logic        ov;
        logic [4:0]  wre;
        a  = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? m_alu : RD1E;
        bf = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? m_alu : RD2E;
        b  = ALUSrcE ? SignImmE : bf;
        ov = 1'b0;
        case (ALUControlE)
            3'b010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b110: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
`ifndef EXE_OVERFLOW_TRAP_EN
        ov = 1'b0;
`endif
        wre = RegDstE ? RdE : RtE;
        if (rst) begin
            e = '{alu: 0, wd: 0, pcb: 0, wr: 0, z: 0, rw: 0, mr: 0, mw: 0, br: 0, ov: 0};
        end else begin
            e.alu = r;  e.wd = bf;  e.pcb = PCPlus4E + {SignImmE[29:0], 2'b00};
            e.wr = wre; e.z = (r == 32'd0);
            e.rw = RegWriteE & ~FlushM & ~ov;
            e.mr = MemtoRegE & ~FlushM;
            e.mw = MemWriteE & ~FlushM & ~ov;
            e.br = BranchE & ~FlushM;
            e.ov = ov & ~FlushM;
        end
        sb.push_back(e);
        #1 chk("WriteRegE", {27'd0, WriteRegE}, {27'd0, wre});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        m_alu = e.alu;
        chk("ALUOutM",    ALUOutM,              e.alu);
        chk("WriteDataM", WriteDataM,           e.wd);
        chk("PCBranchM",  PCBranchM,            e.pcb);
        chk("WriteRegM",  {27'd0, WriteRegM},   {27'd0, e.wr});
        chk("ZeroM",      {31'd0, ZeroM},       {31'd0, e.z});
        chk("ctrlM",      {28'd0, RegWriteM, MemtoRegM, MemWriteM, BranchM},
                          {28'd0, e.rw, e.mr, e.mw, e.br});
        chk("OverflowM",  {31'd0, ov_obs},      {31'd0, e.ov});
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        ALUControlE = c; RD1E = a; RD2E = b;
    endtask

    initial begin
        rst = 1; RD1E = 32'h1234; RD2E = 32'h55; SignImmE = 32'h7; PCPlus4E = 32'h40;
        ResultW = 32'h99; RtE = 5'd3; RdE = 5'd9; RegWriteE = 1; MemtoRegE = 1;
        MemWriteE = 1; BranchE = 1; ALUSrcE = 0; RegDstE = 1; ALUControlE = 3'b010;
        ForwardAE = 2'b00; ForwardBE = 2'b00; FlushM = 0;
        @(negedge clk);
        go(); go();
        chk("reset_alu", ALUOutM, 32'h0);
        chk("reset_rw",  {31'd0, RegWriteM}, 32'h0);

        rst = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; BranchE = 0; RegDstE = 0;
        SignImmE = 32'h0; PCPlus4E = 32'h0;
        op(3'b010, 32'd5, 32'd3); go();
        chk("add5_3", ALUOutM, 32'd8);

        op(3'b010, 32'h8, 32'h8); go();
        ForwardAE = 2'b10; op(3'b010, 32'hDEAD, 32'h1); go();
        chk("fwd_mem", ALUOutM, 32'h11);
        ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'd7; op(3'b110, 32'd2, 32'd0); go();
        chk("fwd_wb_sub", ALUOutM, 32'hFFFFFFFB);
        ForwardBE = 2'b11; op(3'b001, 32'hF0, 32'h0F); go();

        ForwardBE = 2'b00; ALUSrcE = 1; SignImmE = 32'hFFFFFFFC; PCPlus4E = 32'h100;
        op(3'b010, 32'd4, 32'h77); go();
        chk("imm_zero", {31'd0, ZeroM}, 32'd1);
        chk("pcbranch", PCBranchM, 32'hF0);

        ALUSrcE = 0; BranchE = 1; op(3'b110, 32'd9, 32'd9); go();
        chk("beq_branch", {31'd0, BranchM}, 32'd1);
        BranchE = 0;

        op(3'b111, 32'hFFFFFFFF, 32'd1); go();
        chk("slt_neg", ALUOutM, 32'd1);
        op(3'b111, 32'd1, 32'hFFFFFFFF); go();
        chk("slt_swap", ALUOutM, 32'd0);
        op(3'b000, 32'hFF00FF00, 32'h0FF00FF0); go();
        op(3'b011, 32'h5, 32'h6); go();

        RegDstE = 1; RdE = 5'd12; RtE = 5'd3; go();
        chk("wreg_rd", {27'd0, WriteRegM}, 32'd12);
        RegDstE = 0; go();
        chk("wreg_rt", {27'd0, WriteRegM}, 32'd3);

        RegWriteE = 1; MemWriteE = 1; BranchE = 1; MemtoRegE = 1; FlushM = 1;
        op(3'b010, 32'd1, 32'd2); go();
        rst = 1; go();
        rst = 0; FlushM = 0; MemWriteE = 0; BranchE = 0; MemtoRegE = 0;

        op(3'b010, 32'h7FFFFFFF, 32'd1); go();
`ifdef EXE_OVERFLOW_TRAP_EN
        chk("ovf_flag", {31'd0, ov_obs}, 32'd1);
        chk("ovf_rw",   {31'd0, RegWriteM}, 32'd0);
`else
        chk("wrap_alu", ALUOutM, 32'h80000000);
        chk("wrap_rw",  {31'd0, RegWriteM}, 32'd1);
`endif
        op(3'b010, 32'd1, 32'd1); go();
        chk("noovf_rw", {31'd0, RegWriteM}, 32'd1);
        op(3'b110, 32'h80000000, 32'd1); go();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
